// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DUMP,
      DONE
   } dump_state_t;

   localparam int WORD_BYTES = 8;

   // An access is legal when it is word aligned and falls inside the array.
   function automatic logic dmem_legal(input logic [63:0] addr,
                                       input int unsigned addr_lsb,
                                       input int unsigned depth);
      logic [63:0] off_mask;
      off_mask = (64'd1 << addr_lsb) - 64'd1;
      return ((addr & off_mask) == 64'd0) && ((addr >> addr_lsb) < 64'(depth));
   endfunction

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump sequencer: edge-detects the dump request, walks the word index and
// runs the valid/ready handshake.
//
// Handshake: a word transfers on every rising edge where dump_valid and
// dump_ready are both high; while dump_ready is low, dump_valid, idx and the
// presented word hold.
module dmem_dump_fsm
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dump,
   input  logic             dump_ready,
   output logic             busy,
   output logic             dump_valid,
   output logic             dump_done,
   output logic [IDX_W-1:0] idx,
   output dump_state_t      state
);

   logic dump_q;

   // State, index and registered status flags; dump_q remembers last dump level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         dump_q     <= 1'b0;
         busy       <= 1'b0;
         dump_valid <= 1'b0;
         dump_done  <= 1'b0;
      end else begin
         dump_q <= dump;
         case (state)
            IDLE: begin
               if (dump && !dump_q) begin
                  state      <= DUMP;
                  idx        <= '0;
                  busy       <= 1'b1;
                  dump_valid <= 1'b1;
               end
            end
            DUMP: begin
               if (dump_ready) begin
                  if (idx == IDX_W'(DEPTH - 1)) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     dump_valid <= 1'b0;
                     dump_done  <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               // A level held high here does not retrigger: dump_q stays 1.
               if (!dump) begin
                  state     <= IDLE;
                  dump_done <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               dump_valid <= 1'b0;
               dump_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dmem_dump_responder.sv
// Data-memory responder for the LEGv8 core: combinational loads, clocked
// stores, sticky illegal-access flag and a full-image dump port.
module dmem_dump_responder
   import dmem_pkg::*;
#(
   parameter int N        = 64,
   parameter int DEPTH    = 64,
   parameter int ADDR_LSB = 3
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic [N-1:0] DM_addr,
   input  logic [N-1:0] DM_writeData,
   input  logic         DM_writeEnable,
   input  logic         DM_readEnable,
   output logic [N-1:0] DM_readData,
   input  logic         dump,
   output logic         dump_valid,
   input  logic         dump_ready,
   output logic [N-1:0] dump_addr,
   output logic [N-1:0] dump_data,
   output logic         dump_done,
   output logic         busy,
   output logic         dm_error
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [N-1:0]     mem [DEPTH];
   logic [IDX_W-1:0] acc_idx;
   logic [IDX_W-1:0] dump_idx;
   logic             acc_legal;
   logic             dumping;
   logic             store_ok;
   dump_state_t      dump_state;

   assign acc_idx   = DM_addr[ADDR_LSB +: IDX_W];
   assign acc_legal = dmem_legal(64'(DM_addr), ADDR_LSB, DEPTH);
   // Stores are frozen for the whole stream so the presented word is stable.
   assign dumping   = (dump_state == DUMP);
   assign store_ok  = DM_writeEnable && acc_legal && !dumping;

   dmem_dump_fsm #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_fsm (
      .clk        (CLOCK_50),
      .reset      (reset),
      .dump       (dump),
      .dump_ready (dump_ready),
      .busy       (busy),
      .dump_valid (dump_valid),
      .dump_done  (dump_done),
      .idx        (dump_idx),
      .state      (dump_state)
   );

   // Memory array: word i resets to i, legal stores commit when not dumping.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= N'(i);
         end
      end else if (store_ok) begin
         mem[acc_idx] <= DM_writeData;
      end
   end

   // Sticky error: misaligned/out-of-range access, or a store during a dump.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         dm_error <= 1'b0;
      end else if ((DM_writeEnable && (!acc_legal || dumping)) ||
                   (DM_readEnable && !acc_legal)) begin
         dm_error <= 1'b1;
      end
   end

   // Combinational load port; zero when not enabled or illegal.
   always_comb begin
      DM_readData = '0;
      if (DM_readEnable && acc_legal) begin
         DM_readData = mem[acc_idx];
      end
   end

   assign dump_data = mem[dump_idx];
   assign dump_addr = N'(dump_idx) << ADDR_LSB;

endmodule
